// File: rtl/morse_char_buffer.sv
// Display character buffer: newest segment pattern in digit 0, with push, backspace and clear.
// Optional MORSE_BUF_CURSOR_BLINK_EN adds a blinking decimal-point cursor on the next free digit.
module morse_char_buffer #(
  parameter int               DEPTH  = 8,
  parameter int               SEG_W  = 8,
  parameter logic [SEG_W-1:0] BLANK  = 8'hFF,
  parameter bit               SCROLL = 1'b1,
  parameter int               CNT_W  = 4
`ifdef MORSE_BUF_CURSOR_BLINK_EN
  , parameter int             BLINK_DIV = 25_000_000
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   push,
  input  logic                   bksp,
  input  logic                   clr,
  input  logic [SEG_W-1:0]       char_in,
  output logic [DEPTH*SEG_W-1:0] seg_out,
  output logic [CNT_W-1:0]       count,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [SEG_W-1:0] dig_q [DEPTH];
  logic [SEG_W-1:0] dig_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             push_q, bksp_q;
  logic             live_q;
  logic             push_ev_s, bksp_ev_s, clr_ev_s, full_s;

  // live_q is low for the first clock after reset so a button still held
  // through reset only reloads the edge registers instead of firing an event.
  assign push_ev_s = en & live_q & push & ~push_q;
  assign bksp_ev_s = en & live_q & bksp & ~bksp_q;
  assign clr_ev_s  = en & clr;
  assign full_s    = (count_q == CNT_FULL);

  assign count = count_q;
  assign empty = (count_q == CNT_ZERO);
  assign full  = full_s;
  assign ovf   = ovf_q;

  // Next-state: clear beats backspace beats push.
  always_comb begin
    dig_d   = dig_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clr_ev_s) begin
      for (int k = 0; k < DEPTH; k++) dig_d[k] = BLANK;
      count_d = CNT_ZERO;
    end else if (bksp_ev_s) begin
      if (count_q != CNT_ZERO) begin
        for (int k = 0; k < DEPTH - 1; k++) dig_d[k] = dig_q[k+1];
        dig_d[DEPTH-1] = BLANK;
        count_d        = count_q - CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end else if (push_ev_s) begin
      if (!full_s || SCROLL) begin
        for (int k = DEPTH - 1; k > 0; k--) dig_d[k] = dig_q[k-1];
        dig_d[0] = char_in;
      end else begin
        dig_d[0] = dig_q[0];
      end
      if (full_s) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else begin
      ovf_d = 1'b0;
    end
  end

  // Buffer state and edge-history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) dig_q[k] <= BLANK;
      count_q <= CNT_ZERO;
      ovf_q   <= 1'b0;
      push_q  <= 1'b0;
      bksp_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      dig_q   <= dig_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      push_q  <= push;
      bksp_q  <= bksp;
      live_q  <= 1'b1;
    end
  end

`ifdef MORSE_BUF_CURSOR_BLINK_EN
  localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [DIV_W-1:0] div_q;
  logic             phase_q;

  // Free-running blink divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= {DIV_W{1'b0}};
      phase_q <= 1'b0;
    end else if (div_q == DIV_W'(BLINK_DIV - 1)) begin
      div_q   <= {DIV_W{1'b0}};
      phase_q <= ~phase_q;
    end else begin
      div_q   <= div_q + DIV_W'(1);
    end
  end

  // Stored digits out, with the decimal point of the next free digit lit on phase 1.
  always_comb begin
    seg_out = {DEPTH*SEG_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      seg_out[k*SEG_W +: SEG_W] = dig_q[k];
      if (phase_q && !full_s && (count_q == CNT_W'(k))) begin
        seg_out[k*SEG_W + SEG_W - 1] = 1'b0;
      end else begin
        seg_out[k*SEG_W + SEG_W - 1] = dig_q[k][SEG_W-1];
      end
    end
  end
`else
  // Stored digits drive the display directly.
  always_comb begin
    seg_out = {DEPTH*SEG_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) seg_out[k*SEG_W +: SEG_W] = dig_q[k];
  end
`endif

endmodule

// File: tb/tb_morse_char_buffer.sv
// Self-checking bench: a scrolling and a rejecting instance share stimulus and are
// compared every cycle against a digit-vector/count reference model.
module tb_morse_char_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, push = 1'b0, bksp = 1'b0, clr = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic [63:0] seg_s, seg_r;
  logic [3:0]  cnt_s, cnt_r;
  logic        emp_s, emp_r, full_s, full_r, ovf_s, ovf_r;

  int n_vec  = 0;
  int n_miss = 0;

  // model: digit k of instance i is mv[i][8k+:8]; index 0 scrolls, 1 rejects
  logic [63:0] mv [2];
  int          mc [2];
  bit          mo [2];
  bit          prev_p, prev_b, armed;

  always #5 clk = ~clk;

  morse_char_buffer #(.SCROLL(1'b1)) u_scroll (
    .clk(clk), .rst_n(rst_n), .en(en), .push(push), .bksp(bksp), .clr(clr),
    .char_in(char_in), .seg_out(seg_s), .count(cnt_s), .empty(emp_s),
    .full(full_s), .ovf(ovf_s));

  morse_char_buffer #(.SCROLL(1'b0)) u_reject (
    .clk(clk), .rst_n(rst_n), .en(en), .push(push), .bksp(bksp), .clr(clr),
    .char_in(char_in), .seg_out(seg_r), .count(cnt_r), .empty(emp_r),
    .full(full_r), .ovf(ovf_r));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = {64{1'b1}};
      mc[i] = 0;
      mo[i] = 1'b0;
    end
    prev_p = 1'b0;
    prev_b = 1'b0;
    armed  = 1'b0;
  endtask

  task automatic model_step(input bit p, input bit b, input bit c, input bit e,
                            input logic [7:0] ch);
    bit pe, be, ce;
    pe = armed && e && p && !prev_p;
    be = armed && e && b && !prev_b;
    ce = e && c;
    for (int i = 0; i < 2; i++) begin
      mo[i] = 1'b0;
      if (ce) begin
        mv[i] = {64{1'b1}};
        mc[i] = 0;
      end else if (be) begin
        if (mc[i] > 0) begin
          mv[i] = {8'hFF, mv[i][63:8]};
          mc[i] = mc[i] - 1;
        end
      end else if (pe) begin
        if (mc[i] < 8) begin
          mv[i] = {mv[i][55:0], ch};
          mc[i] = mc[i] + 1;
        end else begin
          mo[i] = 1'b1;
          if (i == 0) mv[i] = {mv[i][55:0], ch};
        end
      end
    end
    prev_p = p;
    prev_b = b;
    armed  = 1'b1;
  endtask

  task automatic check_all();
    check_eq("seg_scroll", seg_s, mv[0]);
    check_eq("cnt_scroll", {60'd0, cnt_s}, 64'(mc[0]));
    check_eq("flags_scroll", {61'd0, emp_s, full_s, ovf_s},
             {61'd0, mc[0] == 0, mc[0] == 8, mo[0]});
    check_eq("seg_reject", seg_r, mv[1]);
    check_eq("cnt_reject", {60'd0, cnt_r}, 64'(mc[1]));
    check_eq("flags_reject", {61'd0, emp_r, full_r, ovf_r},
             {61'd0, mc[1] == 0, mc[1] == 8, mo[1]});
  endtask

  task automatic cycle(input bit p, input bit b, input bit c, input bit e,
                       input logic [7:0] ch);
    push = p; bksp = b; clr = c; en = e; char_in = ch;
    @(posedge clk);
    model_step(p, b, c, e, ch);
    #1;
    check_all();
  endtask

  task automatic do_push(input logic [7:0] ch);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, ch);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, ch);
  endtask

  task automatic do_bksp();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic do_clr();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk) rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    // 1: three pushes
    do_push(8'hC0); do_push(8'hF9); do_push(8'hA4);
    check_eq("t1_seg", seg_s, 64'hFFFF_FFFF_FFC0_F9A4);
    check_eq("t1_cnt", {60'd0, cnt_s}, 64'd3);

    // 2: nine pushes into eight digits
    do_clr();
    for (int i = 1; i <= 9; i++) do_push(8'(i));
    check_eq("t2_scroll", seg_s, 64'h0203_0405_0607_0809);
    check_eq("t2_reject", seg_r, 64'h0102_0304_0506_0708);
    check_eq("t2_full", {62'd0, full_s, full_r}, 64'd3);

    // 3: backspace past empty
    do_clr();
    do_push(8'h11); do_push(8'h22); do_push(8'h33);
    for (int i = 0; i < 4; i++) do_bksp();
    check_eq("t3_seg", seg_s, {64{1'b1}});
    check_eq("t3_empty", {63'd0, emp_s}, 64'd1);

    // 4: simultaneous edges, then both held
    do_push(8'h44); do_push(8'h55);
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h66);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_eq("t4_cnt", {60'd0, cnt_s}, 64'd1);

    // 5: clear during a push edge, then events with en low
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    do_push(8'h88); do_push(8'h99);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("t5_cnt", {60'd0, cnt_s}, 64'd2);

    // 6: asynchronous reset with push held
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'hBB);
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'hCC);
    check_eq("t6_hold", {60'd0, cnt_s}, 64'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'hDD);
    check_eq("t6_repress", seg_s[7:0], 64'hDD);

    // random: fill-biased phase, then drain-biased phase
    for (int i = 0; i < 600; i++) begin
      bit b;
      b = (i < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      cycle(1'($urandom_range(0, 1)), b, ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 7) != 0), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
